hit_detect: RTL and testbench

//  Upstream of the hit-flash stage: converts per-player "standing in flame" levels into

---
 rtl/hit_detect.sv | 152 +++++++++++++++
 tb/tb_hit_detect.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hit_detect.sv
// Turns per-player flame-overlap levels into single-cycle hit pulses, tracks lives and
// post-hit invulnerability, and declares round end and winner.
module hit_detect #(
  parameter logic [1:0] LIVES        = 2'd3,
  parameter logic [9:0] INVULN_TICKS = 10'h010
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] timer,
  input  logic       round_start,
  input  logic       p1_in_flame,
  input  logic       p2_in_flame,
  output logic       p1gain,
  output logic       p2gain,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives,
  output logic       p1_invuln,
  output logic       p2_invuln,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {ALIVE = 2'd0, INVULN = 2'd1, DEAD = 2'd2} player_state_t;
  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} round_state_t;

  // Index 0 is P1, index 1 is P2.
  player_state_t state_r [2];
  player_state_t state_s [2];
  logic [1:0]    lives_r [2];
  logic [1:0]    lives_s [2];
  logic [9:0]    stamp_r [2];
  logic [9:0]    stamp_s [2];
  logic [9:0]    elapsed_s [2];
  logic          in_flame_s [2];
  logic          hit_s [2];
  logic          fatal_s [2];
  logic          invuln_r [2];
  round_state_t  round_r;
  round_state_t  round_s;
  logic [1:0]    winner_s;
  logic [1:0]    winner_r;
  logic          game_over_r;
  logic          p1gain_r;
  logic          p2gain_r;

  // Per-player next state: hits only land on ALIVE players while the round is in play.
  always_comb begin
    in_flame_s[0] = p1_in_flame;
    in_flame_s[1] = p2_in_flame;
    for (int i = 0; i < 2; i++) begin
      state_s[i]   = state_r[i];
      lives_s[i]   = lives_r[i];
      stamp_s[i]   = stamp_r[i];
      hit_s[i]     = 1'b0;
      fatal_s[i]   = 1'b0;
      elapsed_s[i] = timer - stamp_r[i];
      case (state_r[i])
        ALIVE: begin
          if (in_flame_s[i] && (round_r == PLAY)) begin
            hit_s[i] = 1'b1;
            if (lives_r[i] <= 2'd1) begin
              lives_s[i] = 2'd0;
              fatal_s[i] = 1'b1;
              state_s[i] = DEAD;
            end else begin
              lives_s[i] = lives_r[i] - 2'd1;
              stamp_s[i] = timer;
              state_s[i] = INVULN;
            end
          end else begin
            state_s[i] = ALIVE;
          end
        end
        INVULN: begin
          // Modular 10-bit difference keeps the window correct across timer wrap.
          if (elapsed_s[i] >= INVULN_TICKS) begin
            state_s[i] = ALIVE;
          end else begin
            state_s[i] = INVULN;
          end
        end
        DEAD:    state_s[i] = DEAD;
        default: state_s[i] = ALIVE;
      endcase
    end
  end

  // Round next state and winner; a fatal hit can only occur while in PLAY.
  always_comb begin
    round_s  = round_r;
    winner_s = winner_r;
    case (round_r)
      PLAY: begin
        if (fatal_s[0] || fatal_s[1]) begin
          round_s = OVER;
        end else begin
          round_s = PLAY;
        end
      end
      OVER:    round_s = OVER;
      default: round_s = PLAY;
    endcase
    if (fatal_s[0] && fatal_s[1]) begin
      winner_s = 2'b11;
    end else if (fatal_s[0]) begin
      winner_s = 2'b10;
    end else if (fatal_s[1]) begin
      winner_s = 2'b01;
    end else begin
      winner_s = winner_r;
    end
  end

  // State and output registers; round_start shares the reset behaviour.
  always_ff @(posedge Clk) begin
    if (Reset || round_start) begin
      for (int i = 0; i < 2; i++) begin
        state_r[i]  <= ALIVE;
        lives_r[i]  <= LIVES;
        stamp_r[i]  <= 10'h000;
        invuln_r[i] <= 1'b0;
      end
      round_r     <= PLAY;
      winner_r    <= 2'b00;
      game_over_r <= 1'b0;
      p1gain_r    <= 1'b0;
      p2gain_r    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_r[i]  <= state_s[i];
        lives_r[i]  <= lives_s[i];
        stamp_r[i]  <= stamp_s[i];
        invuln_r[i] <= (state_s[i] == INVULN);
      end
      round_r     <= round_s;
      winner_r    <= winner_s;
      game_over_r <= (round_s == OVER);
      p1gain_r    <= hit_s[1];
      p2gain_r    <= hit_s[0];
    end
  end

  assign p1gain    = p1gain_r;
  assign p2gain    = p2gain_r;
  assign p1_lives  = lives_r[0];
  assign p2_lives  = lives_r[1];
  assign p1_invuln = invuln_r[0];
  assign p2_invuln = invuln_r[1];
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_hit_detect.sv
// Directed bench for hit_detect: a vector table for the main game flow plus hand-written
// sequences for long flame holds, timer wrap and Reset priority.
module tb_hit_detect;

  logic       Clk;
  logic       Reset;
  logic [9:0] timer;
  logic       round_start;
  logic       p1_in_flame;
  logic       p2_in_flame;
  logic       p1gain;
  logic       p2gain;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic       p1_invuln;
  logic       p2_invuln;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  hit_detect dut (
    .Clk(Clk), .Reset(Reset), .timer(timer), .round_start(round_start),
    .p1_in_flame(p1_in_flame), .p2_in_flame(p2_in_flame),
    .p1gain(p1gain), .p2gain(p2gain), .p1_lives(p1_lives), .p2_lives(p2_lives),
    .p1_invuln(p1_invuln), .p2_invuln(p2_invuln), .game_over(game_over), .winner(winner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] t;
    logic       rs, f1, f2;
    logic       g1, g2;
    logic [1:0] l1, l2;
    logic       i1, i2, go;
    logic [1:0] w;
  } vec_t;

  vec_t tv [21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {p1gain, p2gain, p1_lives, p2_lives, p1_invuln, p2_invuln, game_over, winner};
  endfunction

  initial begin
    int          hits;
    logic [9:0]  hit_t [2];
    logic        p1g_seen;

    //           t        rs   f1   f2    g1   g2    l1   l2    i1   i2   go    w
    tv[0]  = '{10'h000, 1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd3,2'd3, 1'b0,1'b0,1'b0, 2'b00};
    tv[1]  = '{10'h020, 1'b0,1'b1,1'b0, 1'b0,1'b1, 2'd2,2'd3, 1'b1,1'b0,1'b0, 2'b00};
    tv[2]  = '{10'h021, 1'b0,1'b1,1'b0, 1'b0,1'b0, 2'd2,2'd3, 1'b1,1'b0,1'b0, 2'b00};
    tv[3]  = '{10'h030, 1'b0,1'b1,1'b0, 1'b0,1'b0, 2'd2,2'd3, 1'b0,1'b0,1'b0, 2'b00};
    tv[4]  = '{10'h030, 1'b0,1'b1,1'b0, 1'b0,1'b1, 2'd1,2'd3, 1'b1,1'b0,1'b0, 2'b00};
    tv[5]  = '{10'h031, 1'b0,1'b0,1'b1, 1'b1,1'b0, 2'd1,2'd2, 1'b1,1'b1,1'b0, 2'b00};
    tv[6]  = '{10'h041, 1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd1,2'd2, 1'b0,1'b0,1'b0, 2'b00};
    tv[7]  = '{10'h042, 1'b0,1'b0,1'b1, 1'b1,1'b0, 2'd1,2'd1, 1'b0,1'b1,1'b0, 2'b00};
    tv[8]  = '{10'h052, 1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd1,2'd1, 1'b0,1'b0,1'b0, 2'b00};
    tv[9]  = '{10'h053, 1'b0,1'b1,1'b1, 1'b1,1'b1, 2'd0,2'd0, 1'b0,1'b0,1'b1, 2'b11};
    tv[10] = '{10'h054, 1'b1,1'b1,1'b0, 1'b0,1'b0, 2'd3,2'd3, 1'b0,1'b0,1'b0, 2'b00};
    tv[11] = '{10'h055, 1'b0,1'b1,1'b0, 1'b0,1'b1, 2'd2,2'd3, 1'b1,1'b0,1'b0, 2'b00};
    tv[12] = '{10'h065, 1'b0,1'b0,1'b1, 1'b1,1'b0, 2'd2,2'd2, 1'b0,1'b1,1'b0, 2'b00};
    tv[13] = '{10'h075, 1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd2,2'd2, 1'b0,1'b0,1'b0, 2'b00};
    tv[14] = '{10'h075, 1'b0,1'b0,1'b1, 1'b1,1'b0, 2'd2,2'd1, 1'b0,1'b1,1'b0, 2'b00};
    tv[15] = '{10'h085, 1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd2,2'd1, 1'b0,1'b0,1'b0, 2'b00};
    tv[16] = '{10'h086, 1'b0,1'b1,1'b1, 1'b1,1'b1, 2'd1,2'd0, 1'b1,1'b0,1'b1, 2'b01};
    tv[17] = '{10'h087, 1'b0,1'b1,1'b0, 1'b0,1'b0, 2'd1,2'd0, 1'b1,1'b0,1'b1, 2'b01};
    tv[18] = '{10'h096, 1'b0,1'b1,1'b0, 1'b0,1'b0, 2'd1,2'd0, 1'b0,1'b0,1'b1, 2'b01};
    tv[19] = '{10'h097, 1'b0,1'b1,1'b0, 1'b0,1'b0, 2'd1,2'd0, 1'b0,1'b0,1'b1, 2'b01};
    tv[20] = '{10'h098, 1'b1,1'b0,1'b0, 1'b0,1'b0, 2'd3,2'd3, 1'b0,1'b0,1'b0, 2'b00};

    Reset = 1'b1; round_start = 1'b0; p1_in_flame = 1'b0; p2_in_flame = 1'b0;
    timer = 10'h000;
    cycle();
    cycle();
    Reset = 1'b0;

    // Main game flow from the table
    for (int i = 0; i < 21; i++) begin
      timer       = tv[i].t;
      round_start = tv[i].rs;
      p1_in_flame = tv[i].f1;
      p2_in_flame = tv[i].f2;
      cycle();
      check($sformatf("vec%0d", i), {5'd0, outs()},
            {5'd0, tv[i].g1, tv[i].g2, tv[i].l1, tv[i].l2, tv[i].i1, tv[i].i2, tv[i].go, tv[i].w});
    end
    round_start = 1'b0;

    // Reset beats a pending hit and clears invulnerability
    timer = 10'h0A0; p1_in_flame = 1'b1; p2_in_flame = 1'b0;
    cycle();
    check("pre_reset_hit", {5'd0, outs()}, {5'd0, 1'b0, 1'b1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 2'b00});
    Reset = 1'b1; p2_in_flame = 1'b1;
    cycle();
    check("reset_priority", {5'd0, outs()}, {5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00});
    Reset = 1'b0; p1_in_flame = 1'b0; p2_in_flame = 1'b0;

    // Long flame hold, timer advancing one unit every 4 clocks
    hits = 0; p1g_seen = 1'b0;
    hit_t[0] = 10'h3FF; hit_t[1] = 10'h3FF;
    for (int u = 'h20; u < 'h40; u++) begin
      for (int k = 0; k < 4; k++) begin
        timer = u[9:0]; p1_in_flame = 1'b1;
        cycle();
        if (p2gain) begin
          if (hits < 2) hit_t[hits] = timer;
          hits++;
        end
        if (p1gain) p1g_seen = 1'b1;
      end
    end
    p1_in_flame = 1'b0;
    check("hold_hit_count", 16'(hits), 16'd2);
    check("hold_hit0_time", {6'd0, hit_t[0]}, 16'h0020);
    check("hold_hit1_time", {6'd0, hit_t[1]}, 16'h0030);
    check("hold_p1_lives", {14'd0, p1_lives}, 16'd1);
    check("hold_no_p1gain", {15'd0, p1g_seen}, 16'd0);

    // Invulnerability across timer wrap
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    timer = 10'h3F8; p1_in_flame = 1'b1;
    cycle();
    check("wrap_hit", {13'd0, p2gain, p1_invuln, p1gain}, 16'b110);
    p1_in_flame = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      timer = timer + 10'd1;
      cycle();
      check($sformatf("wrap_invuln_n%0d", n), {15'd0, p1_invuln}, {15'd0, (n < 16)});
      if (timer == 10'h008) check("wrap_clear_at_008", {15'd0, p1_invuln}, 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
